// File: rtl/prom_pattern_player_if.sv
`default_nettype none
// ============================================================================
// Module   : prom_pattern_player_if
// Purpose  : Synchronous ROM bus between the pattern player and a pROM.
// Revision : 1.0 - initial release
// ============================================================================
interface prom_pattern_player_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_ad;
    logic              rom_ce;
    logic [DATA_W-1:0] rom_dout;

    modport master (output rom_ad, output rom_ce, input rom_dout);
    modport slave  (input rom_ad, input rom_ce, output rom_dout);
endinterface
`default_nettype wire

// File: rtl/prom_pattern_player.sv
`default_nettype none
// ============================================================================
// Module   : prom_pattern_player
// Purpose  : Steps a synchronous ROM at a fixed rate and presents each word on
//            a registered pattern output (loop / ping-pong / one-shot).
//            Ping-pong direction logic is built only with PLAYER_PINGPONG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prom_pattern_player #(
    parameter int CLK_HZ   = 27000000,
    parameter int STEP_HZ  = 2,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 6,
    parameter int READ_LAT = 1
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 start,
    input  wire logic                 stop,
    input  wire logic [1:0]           mode,
    prom_pattern_player_if.master     rom,
    output logic      [OUT_W-1:0]     pat_out,
    output logic                      step_pulse,
    output logic                      busy,
    output logic                      done
);
    localparam int PERIOD = CLK_HZ / STEP_HZ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [CNT_W-1:0]  LAT_CNT  = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PERIOD - 1);
    localparam logic [ADDR_W-1:0] LAST_AD  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        MODE_PP  = 2'b01;
    localparam logic [1:0]        MODE_ONE = 2'b10;

    if (PERIOD < READ_LAT + 2) begin : g_chk_period
        $error("prom_pattern_player: PERIOD must be at least READ_LAT+2");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_chk_depth
        $error("prom_pattern_player: DEPTH must be in 1..2^ADDR_W");
    end
    if (READ_LAT < 1 || READ_LAT > 3) begin : g_chk_lat
        $error("prom_pattern_player: READ_LAT must be in 1..3");
    end
    if (OUT_W > DATA_W) begin : g_chk_width
        $error("prom_pattern_player: OUT_W must not exceed DATA_W");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_ad_q, rom_ad_d;
    logic [OUT_W-1:0]  pat_q, pat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              step_q, step_d;
    logic [ADDR_W-1:0] nxt_ad;
    logic              finished;
`ifdef PLAYER_PINGPONG_EN
    logic              dir_up_q, dir_up_d, nxt_up;
`endif

    // Upper ROM bits beyond the pattern width are intentionally discarded.
    logic unused_dout;
    assign unused_dout = ^rom.rom_dout;

    always_comb begin
        nxt_ad   = (rom_ad_q == LAST_AD) ? '0 : rom_ad_q + 1'b1;
        finished = (mode_q == MODE_ONE) && (rom_ad_q == LAST_AD);
`ifdef PLAYER_PINGPONG_EN
        nxt_up   = dir_up_q;
        if (mode_q == MODE_PP && DEPTH > 1) begin
            if (dir_up_q) begin
                if (rom_ad_q == LAST_AD) begin
                    nxt_up = 1'b0;
                    nxt_ad = rom_ad_q - 1'b1;
                end
            end else if (rom_ad_q == '0) begin
                nxt_up = 1'b1;
                nxt_ad = rom_ad_q + 1'b1;
            end else begin
                nxt_ad = rom_ad_q - 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        rom_ad_d = rom_ad_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = done_q;
        step_d   = 1'b0;
`ifdef PLAYER_PINGPONG_EN
        dir_up_d = dir_up_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    mode_d   = mode;
                    done_d   = 1'b0;
                    rom_ad_d = '0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
`ifdef PLAYER_PINGPONG_EN
                    dir_up_d = 1'b1;
`endif
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAT_CNT) begin
                    pat_d   = rom.rom_dout[OUT_W-1:0];
                    step_d  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + 1'b1;
                // cnt counts cycles since the last address load; PERIOD-1 closes the step.
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (finished) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        rom_ad_d = nxt_ad;
`ifdef PLAYER_PINGPONG_EN
                        dir_up_d = nxt_up;
`endif
                        state_d  = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (stop && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            step_d   = 1'b0;
            pat_d    = pat_q;
            rom_ad_d = rom_ad_q;
            done_d   = done_q;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rom_ad_q <= '0;
            pat_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            step_q   <= 1'b0;
`ifdef PLAYER_PINGPONG_EN
            dir_up_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            rom_ad_q <= rom_ad_d;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            step_q   <= step_d;
`ifdef PLAYER_PINGPONG_EN
            dir_up_q <= dir_up_d;
`endif
        end
    end

    assign rom.rom_ad = rom_ad_q;
    assign rom.rom_ce = busy_q;
    assign pat_out    = pat_q;
    assign step_pulse = step_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule
`default_nettype wire

// File: tb/tb_prom_pattern_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_prom_pattern_player
// Purpose  : Randomised scoreboard bench for prom_pattern_player (PERIOD=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prom_pattern_player;
    localparam int CLK_HZ = 16, STEP_HZ = 2, PER = 8;
    localparam int ADDR_W = 4, DEPTH = 4, DATA_W = 8, OUT_W = 6, READ_LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic             start = 1'b0, stop = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [OUT_W-1:0] pat_out;
    logic             step_pulse, busy, done;

    logic             start1 = 1'b0, stop1 = 1'b0;
    logic [1:0]       mode1 = 2'b00;
    logic [OUT_W-1:0] pat1;
    logic             step1, busy1, done1;

    prom_pattern_player_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rom_bus ();
    prom_pattern_player_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rom_bus1 ();

    prom_pattern_player #(
        .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .DATA_W(DATA_W), .OUT_W(OUT_W), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .rom(rom_bus), .pat_out(pat_out), .step_pulse(step_pulse),
        .busy(busy), .done(done)
    );

    prom_pattern_player #(
        .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .ADDR_W(ADDR_W), .DEPTH(1),
        .DATA_W(DATA_W), .OUT_W(OUT_W), .READ_LAT(READ_LAT)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .mode(mode1),
        .rom(rom_bus1), .pat_out(pat1), .step_pulse(step1),
        .busy(busy1), .done(done1)
    );

    // ROM models, content addr*0x11, one cycle read latency.
    always @(posedge clk) if (rom_bus.rom_ce)
        rom_bus.rom_dout <= 8'(32'(rom_bus.rom_ad) * 17);
    always @(posedge clk) if (rom_bus1.rom_ce)
        rom_bus1.rom_dout <= 8'(32'(rom_bus1.rom_ad) * 17);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_pass = 0;
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct { int t; int ad; int pat; } step_t;
    step_t sq[$];
    int    dq[$];
    int    exp_pat = 0;
    int    exp_ad  = 0;

    function automatic int ref_addr(input int m, input int k);
        int span;
        span = 0;
        if (m == 1) begin
`ifdef PLAYER_PINGPONG_EN
            if (DEPTH == 1) return 0;
            span = 2 * (DEPTH - 1);
            return ((k % span) < DEPTH) ? (k % span) : span - (k % span);
`else
            return k % DEPTH;
`endif
        end
        return k % DEPTH + span;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a step or done.
    step_t mon_e;
    logic  done_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (step_pulse) begin
                if (sq.size() == 0) check("unexpected_step", cyc, -1);
                else begin
                    mon_e = sq.pop_front();
                    check("step_cycle", cyc, mon_e.t);
                    check("step_pat", int'(pat_out), mon_e.pat);
                    check("step_addr", int'(rom_bus.rom_ad), mon_e.ad);
                end
            end
            if (done && !done_prev) begin
                if (dq.size() == 0) check("unexpected_done", cyc, -1);
                else begin
                    check("done_cycle", cyc, dq.pop_front());
                    check("busy_at_done", int'(busy), 0);
                end
            end
        end
        done_prev = done;
    end

    int   p1_cnt = 0, p1_cyc = -1, p1_pat = -1, d1_cyc = -1;
    logic d1_prev = 1'b0;
    always @(negedge clk) begin
        if (step1) begin
            p1_cnt++;
            p1_cyc = cyc;
            p1_pat = int'(pat1);
        end
        if (done1 && !d1_prev) d1_cyc = cyc;
        d1_prev = done1;
    end

    task automatic run(input int m, input int len, input bit ss_start);
        int c, e, a, kmax;
        @(posedge clk); #1;
        c = cyc;
        e = c + 1 + PER * DEPTH;
        start = 1'b1;
        mode  = 2'(m);
        for (int k = 0; k < ((m == 2) ? DEPTH : 64); k++) begin
            if (c + 3 + PER * k <= c + len) begin
                a = ref_addr(m, k);
                sq.push_back('{t: c + 3 + PER * k, ad: a, pat: (a * 17) & 63});
                exp_pat = (a * 17) & 63;
            end
        end
        if (m == 2 && e <= c + len) dq.push_back(e);
        kmax = (len - 1) / PER;
        if (m == 2 && kmax > DEPTH - 1) kmax = DEPTH - 1;
        exp_ad = ref_addr(m, kmax);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("done_clear", int'(done), 0);
        check("addr_after_start", int'(rom_bus.rom_ad), 0);
        while (cyc < c + len) begin
            check("busy_level", int'(busy), (m == 2 && cyc >= e) ? 0 : 1);
            start = (m != 2 || cyc < e - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            mode  = 2'($urandom);
            @(posedge clk); #1;
        end
        start = ss_start;
        stop  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        check("busy_after_stop", int'(busy), 0);
        check("ce_after_stop", int'(rom_bus.rom_ce), 0);
        repeat (2 * PER) @(posedge clk);
        #1;
        check("pat_hold", int'(pat_out), exp_pat);
        check("addr_hold", int'(rom_bus.rom_ad), exp_ad);
        check("done_level", int'(done), (m == 2 && e <= c + len) ? 1 : 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    int c0;
    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_pat", int'(pat_out), 0);
        check("rst_step", int'(step_pulse), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ad", int'(rom_bus.rom_ad), 0);
        check("rst_ce", int'(rom_bus.rom_ce), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        run(0, 40, 1'b0);
        run(1, 62, 1'b0);
        run(2, 45, 1'b0);
        run(3, 30, 1'b1);
        for (int i = 0; i < 8; i++)
            run(int'($urandom_range(0, 3)), int'($urandom_range(2, 70)), 1'($urandom));

        // Asynchronous reset in the middle of a loop playback.
        @(posedge clk); #1;
        c0 = cyc;
        start = 1'b1;
        mode  = 2'b00;
        sq.push_back('{t: c0 + 3,  ad: 0, pat: 0});
        sq.push_back('{t: c0 + 11, ad: 1, pat: 17});
        @(posedge clk); #1 start = 1'b0;
        while (cyc < c0 + 13) begin
            @(posedge clk); #1;
        end
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_pat", int'(pat_out), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ad", int'(rom_bus.rom_ad), 0);
        check("mid_rst_ce", int'(rom_bus.rom_ce), 0);
        check("mid_rst_step", int'(step_pulse), 0);
        @(negedge clk) rst_n = 1'b1;
        exp_pat = 0;
        repeat (3 * PER) @(posedge clk);
        #1;
        check("idle_after_rst", int'(busy), 0);
        check("pat_after_rst", int'(pat_out), 0);

        // DEPTH=1 one-shot.
        @(posedge clk); #1;
        c0 = cyc;
        start1 = 1'b1;
        mode1  = 2'b10;
        @(posedge clk); #1 start1 = 1'b0;
        repeat (3 * PER) @(posedge clk);
        #1;
        check("d1_pulses", p1_cnt, 1);
        check("d1_pulse_cycle", p1_cyc, c0 + 3);
        check("d1_pat", p1_pat, 0);
        check("d1_done_cycle", d1_cyc, c0 + 1 + PER);
        check("d1_busy", int'(busy1), 0);
        check("d1_done", int'(done1), 1);

        check("leftover_steps", sq.size(), 0);
        check("leftover_done", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
